// File: rtl/fetch_sequencer.sv
// Fetch-side PC sequencer: advances/redirects the program counter and arbitrates the
// single-ported instruction cache against a beat-streaming block loader.
module fetch_sequencer #(
  parameter int PC_WIDTH      = 16,
  parameter int BLOCK_SIZE    = 32,
  parameter int BITS_PER_BYTE = 8,
  parameter int BEAT_WIDTH    = 64,
  parameter int RESET_PC      = 0
) (
  input  logic                                    clock_i,
  input  logic                                    reset_i,
  input  logic                                    stall_i,
  input  logic                                    offsetValid_i,
  input  logic [3:0]                              nextByteOffset_i,
  input  logic                                    redirect_i,
  input  logic [PC_WIDTH-1:0]                     redirectPC_i,
  input  logic                                    fillStart_i,
  input  logic [PC_WIDTH-1:0]                     fillAddr_i,
  input  logic                                    fillBeatValid_i,
  input  logic [BEAT_WIDTH-1:0]                   fillBeat_i,
  output logic                                    fillReady_o,
  output logic                                    fillBusy_o,
  output logic                                    fillDone_o,
  output logic [PC_WIDTH-1:0]                     PC_o,
  output logic                                    fetchEnable_o,
  output logic                                    writeEnable_o,
  output logic [PC_WIDTH-1:0]                     writeAddress_o,
  output logic [BLOCK_SIZE*BITS_PER_BYTE-1:0]     writeBlock_o
);

  localparam int BLOCK_BITS = BLOCK_SIZE * BITS_PER_BYTE;
  localparam int BEATS      = BLOCK_BITS / BEAT_WIDTH;
  localparam int OFF_BITS   = $clog2(BLOCK_SIZE);
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e                  state_q,  state_d;
  logic [PC_WIDTH-1:0]     pc_q,     pc_d;
  logic                    bubble_q, bubble_d;
  logic                    busy_q,   busy_d;
  logic                    ready_q,  ready_d;
  logic [CNT_W-1:0]        cnt_q,    cnt_d;
  logic [PC_WIDTH-1:0]     waddr_q,  waddr_d;
  logic [BLOCK_BITS-1:0]   block_q,  block_d;

  // Byte-offset bits of the fill address are discarded by block alignment.
  logic unused_fill_offset;
  assign unused_fill_offset = ^fillAddr_i[OFF_BITS-1:0];

  // State and datapath registers; reset discards any partial fill.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= ST_IDLE;
      pc_q     <= PC_WIDTH'(RESET_PC);
      bubble_q <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      waddr_q  <= {PC_WIDTH{1'b0}};
      block_q  <= {BLOCK_BITS{1'b0}};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      bubble_q <= bubble_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
      waddr_q  <= waddr_d;
      block_q  <= block_d;
    end
  end

  // Next-state: PC sequencing (redirect > stall > advance) and fill beat packing.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    bubble_d = 1'b0;
    busy_d   = busy_q;
    ready_d  = ready_q;
    cnt_d    = cnt_q;
    waddr_d  = waddr_q;
    block_d  = block_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect_i) begin
          pc_d     = redirectPC_i;
          bubble_d = 1'b1;
        end else if (stall_i) begin
          pc_d = pc_q;
        end else if (offsetValid_i) begin
          pc_d = pc_q + {{(PC_WIDTH-4){1'b0}}, nextByteOffset_i};
        end else begin
          pc_d = pc_q;
        end

        if (!busy_q && fillStart_i) begin
          busy_d  = 1'b1;
          ready_d = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          waddr_d = {fillAddr_i[PC_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
        end else if (ready_q && fillBeatValid_i) begin
          block_d[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = fillBeat_i;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BEATS-1)) begin
            ready_d = 1'b0;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_WRITE: begin
        // Cache port belongs to the write; a redirect seen now lands on the edge back into FETCH.
        state_d = ST_FETCH;
        busy_d  = 1'b0;
        if (redirect_i) begin
          pc_d     = redirectPC_i;
          bubble_d = 1'b1;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign PC_o           = pc_q;
  assign fetchEnable_o  = (state_q == ST_FETCH) && !bubble_q;
  assign writeEnable_o  = (state_q == ST_WRITE);
  assign fillDone_o     = (state_q == ST_WRITE);
  assign fillBusy_o     = busy_q;
  assign fillReady_o    = ready_q;
  assign writeAddress_o = waddr_q;
  assign writeBlock_o   = block_q;

endmodule
